// File: rtl/btn_sw_debounce_pkg.sv
// Shared definitions for the button/switch debouncer: default stability window,
// counter width helper and the per-bit debounce state type.
package btn_sw_debounce_pkg;

    localparam int DB_CYCLES_DEF = 500000;

    // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input lane: two-flop synchronizer, stability counter and registered
// rise/fall pulses that coincide with the debounced level changing.
module debounce_bit
    import btn_sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_s1, r_s2, r_q, r_rise, r_fall;
    db_state_t     r_st;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_st   <= ST_STABLE;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_st)
                ST_STABLE: begin
                    if (r_s2 != r_q) begin
                        r_st  <= ST_SETTLING;
                        r_cnt <= CW'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_SETTLING: begin
                    // Any bounce back to the accepted level throws away progress.
                    if (r_s2 == r_q) begin
                        r_st  <= ST_STABLE;
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_q    <= r_s2;
                        r_rise <= r_s2;
                        r_fall <= ~r_s2;
                        r_cnt  <= '0;
                        r_st   <= ST_STABLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_st  <= ST_STABLE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/btn_sw_debounce.sv
// Debounces NBTN buttons and NSW switches into clean levels plus one-cycle pulses.
// Define BTN_AUTO_REPEAT_EN to add held-button auto-repeat press pulses.
module btn_sw_debounce
    import btn_sw_debounce_pkg::*;
#(
    parameter int NBTN          = 5,
    parameter int NSW           = 8,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    input  logic [NSW-1:0]  sw_raw,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NSW-1:0]  sw,
    output logic [NSW-1:0]  sw_chg
);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_chk
        $error("btn_sw_debounce: DB_CYCLES and REPEAT_* must be >= 2");
    end

    logic [NBTN-1:0] w_btn_rise;
    logic [NSW-1:0]  w_sw_rise, w_sw_fall;

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (btn_raw[g]),
            .o_q    (btn[g]),
            .o_rise (w_btn_rise[g]),
            .o_fall (btn_release[g])
        );
    end

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (sw_raw[g]),
            .o_q    (sw[g]),
            .o_rise (w_sw_rise[g]),
            .o_fall (w_sw_fall[g])
        );
    end

    assign sw_chg = w_sw_rise | w_sw_fall;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW        = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [NBTN-1:0]         r_rep, r_first;
    logic [NBTN-1:0][RW-1:0] r_rep_cnt;

    // Counter restarts at 1 the cycle after any visible press pulse, so the
    // count equals cycles elapsed since that pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep     <= '0;
            r_first   <= '0;
            r_rep_cnt <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (!btn[i]) begin
                    r_rep[i]     <= 1'b0;
                    r_first[i]   <= 1'b0;
                    r_rep_cnt[i] <= '0;
                end else if (btn_press[i]) begin
                    r_rep[i]     <= 1'b0;
                    r_first[i]   <= w_btn_rise[i];
                    r_rep_cnt[i] <= RW'(1);
                end else begin
                    r_rep[i]     <= (r_rep_cnt[i] == (r_first[i] ? REP_FIRST : REP_NEXT));
                    r_rep_cnt[i] <= r_rep_cnt[i] + RW'(1);
                end
            end
        end
    end

    // Masking with the level suppresses a repeat landing on the release cycle.
    assign btn_press = w_btn_rise | (r_rep & btn);
`else
    assign btn_press = w_btn_rise;
`endif

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Self-checking bench for btn_sw_debounce (DB_CYCLES=4); the run-length model
// pushes one expected output set per clock edge, popped and compared half a cycle later.
module tb_btn_sw_debounce;

    localparam int NB = 5;
    localparam int NS = 8;
    localparam int DB = 4;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RD = 10;
    localparam int RP = 3;
    int nxt[NB];
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw, btn, btn_press, btn_release;
    logic [NS-1:0] sw_raw, sw, sw_chg;

    always #5 clk = ~clk;

    btn_sw_debounce #(
        .NBTN(NB), .NSW(NS), .DB_CYCLES(DB), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn(btn), .btn_press(btn_press), .btn_release(btn_release),
        .sw(sw), .sw_chg(sw_chg)
    );

    typedef struct {
        logic [NB-1:0] btn, press, rel;
        logic [NS-1:0] sw, chg;
    } exp_t;

    exp_t             sb[$];
    int               n_chk = 0, n_fail = 0, cyc = 0;
    int               np[NB], nr[NB], run[NB+NS];
    logic [NB+NS-1:0] m_s1, m_s2, m_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A level is accepted once the synchronized input has differed from it for DB consecutive edges.
    task automatic model_step();
        exp_t             e;
        logic [NB+NS-1:0] rise, fall;
        logic [NB-1:0]    rep;
        rise = '0; fall = '0; rep = '0;
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_q = '0;
            for (int i = 0; i < NB+NS; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < NB+NS; i++) begin
                if (m_s2[i] != m_q[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_q[i]  = m_s2[i];
                        rise[i] = m_s2[i];
                        fall[i] = ~m_s2[i];
                        run[i]  = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_raw, btn_raw};
`ifdef BTN_AUTO_REPEAT_EN
            for (int b = 0; b < NB; b++) begin
                if (rise[b]) nxt[b] = cyc + RD;
                else if (m_q[b] && cyc == nxt[b]) begin
                    rep[b] = 1'b1;
                    nxt[b] = cyc + RP;
                end
            end
`endif
        end
        e.btn   = m_q[NB-1:0];
        e.press = rise[NB-1:0] | rep;
        e.rel   = fall[NB-1:0];
        e.sw    = m_q[NB+NS-1:NB];
        e.chg   = rise[NB+NS-1:NB] | fall[NB+NS-1:NB];
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            e = sb.pop_front();
            chk("sb_btn", 32'(btn), 32'(e.btn));
            chk("sb_press", 32'(btn_press), 32'(e.press));
            chk("sb_release", 32'(btn_release), 32'(e.rel));
            chk("sb_sw", 32'(sw), 32'(e.sw));
            chk("sb_sw_chg", 32'(sw_chg), 32'(e.chg));
            for (int b = 0; b < NB; b++) begin
                np[b] += int'(btn_press[b]);
                nr[b] += int'(btn_release[b]);
            end
        end
    endtask

    initial begin
        int p, r, idx;
        for (int b = 0; b < NB; b++) begin np[b] = 0; nr[b] = 0; end
        rst = 1'b1; btn_raw = '0; sw_raw = 8'hA5;

        // switches held through reset
        tick(2);
        chk("rst_btn", 32'(btn), 0);
        chk("rst_sw", 32'(sw), 0);
        rst = 1'b0;
        tick(5);
        chk("sw_before_accept", 32'(sw), 0);
        tick(1);
        chk("sw_accept", 32'(sw), 32'hA5);
        chk("sw_chg_pulse", 32'(sw_chg), 32'hA5);
        tick(1);
        chk("sw_chg_one_cycle", 32'(sw_chg), 0);

        // clean press on btn0
        p = np[0]; r = nr[0];
        btn_raw[0] = 1'b1;
        tick(5);
        chk("b0_before_accept", 32'(btn[0]), 0);
        tick(1);
        chk("b0_accept", 32'(btn[0]), 1);
        chk("b0_press_pulse", 32'(btn_press[0]), 1);
        tick(1);
        chk("b0_press_one_cycle", 32'(btn_press[0]), 0);
        tick(4);
        chk("b0_press_count", np[0] - p, 1);
        chk("b0_no_release", nr[0] - r, 0);

        // bounce on btn2, then settle high
        p = np[2];
        for (int i = 0; i < 10; i++) begin
            btn_raw[2] = (i % 2 == 0);
            tick(2);
        end
        chk("b2_bounce_no_press", np[2] - p, 0);
        chk("b2_bounce_level", 32'(btn[2]), 0);
        btn_raw[2] = 1'b1;
        tick(5);
        chk("b2_before_accept", 32'(btn[2]), 0);
        tick(1);
        chk("b2_accept", 32'(btn[2]), 1);
        tick(2);
        chk("b2_press_count", np[2] - p, 1);

        // release on btn1
        btn_raw[1] = 1'b1;
        tick(8);
        p = np[1]; r = nr[1];
        btn_raw[1] = 1'b0;
        tick(5);
        chk("b1_before_release", 32'(btn[1]), 1);
        tick(1);
        chk("b1_released", 32'(btn[1]), 0);
        chk("b1_release_pulse", 32'(btn_release[1]), 1);
        tick(1);
        chk("b1_release_one_cycle", 32'(btn_release[1]), 0);
        chk("b1_release_count", nr[1] - r, 1);
        chk("b1_no_press", np[1] - p, 0);

        // reset in the middle of settling on btn3
        btn_raw[3] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("b3_rst_level", 32'(btn[3]), 0);
        rst = 1'b0;
        tick(1);
        chk("b3_no_pulse_after_rst", 32'(btn_press), 0);
        p = np[3];
        tick(4);
        chk("b3_before_accept", 32'(btn[3]), 0);
        tick(1);
        chk("b3_accept", 32'(btn[3]), 1);
        tick(2);
        chk("b3_press_count", np[3] - p, 1);

        // long hold on btn4; release lands on a would-be repeat cycle
        p = np[4]; r = nr[4];
        btn_raw[4] = 1'b1;
        tick(37);
        btn_raw[4] = 1'b0;
        tick(13);
`ifdef BTN_AUTO_REPEAT_EN
        chk("b4_press_count_repeat", np[4] - p, 10);
`else
        chk("b4_press_count", np[4] - p, 1);
`endif
        chk("b4_release_count", nr[4] - r, 1);

        // random toggling with mixed run lengths, checked by the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, NB-1));
                btn_raw[idx] = ~btn_raw[idx];
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, NS-1));
                sw_raw[idx] = ~sw_raw[idx];
            end
            tick(1);
        end
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
